mod_exp_engine: RTL
===================

// Module: mod_exp_engine
// PURPOSE
//  Parametrised modular exponentiation core: result = base^exponent mod modulo.
//  Used by the RSA encrypt/decrypt datapath. Successor to the fixed-latency divider-IP engine.
//  Uses its own iterative shift-subtract reducers, a start/done handshake and an error flag.
//  Supports back-to-back operations. Arithmetic is right-to-left binary (square-and-multiply).
// PARAMETERS
//  WIDTH     32  operand width in bits (base, modulo, exponent, result); legal 8..64
// PORTS
//  clk       in   1        single clock; all logic on posedge
//  reset     in   1        synchronous, active-high; aborts any operation
//  start     in   1        1-cycle request; sampled only when busy==0
//  base      in   WIDTH    operand, captured on accepted start; may be >= modulo
//  modulo    in   WIDTH    operand, captured on accepted start
//  exponent  in   WIDTH    operand, captured on accepted start
//  busy      out  1        high from cycle after accepted start until done
//  done      out  1        1-cycle pulse; result/error valid in that cycle
//  error     out  1        valid with done; 1 iff captured modulo==0
//  result    out  WIDTH    held from done until next accepted start
// BEHAVIOUR
//  Reset: busy=0, done=0, error=0, result=0, FSM=IDLE; both reducers idle. Applies mid-operation.
//  start while busy=1 is ignored (no queueing). Inputs are don't-care except in the start cycle.
//  FSM: IDLE -start-> CHECK -> PREP -> LOOP <-> STEP; LOOP -exp==0-> DONE -> IDLE.
//  CHECK (1 cycle):
//   - modulo==0: go to DONE with error=1, result=0.
//   - modulo==1: go to DONE with error=0, result=0.
//   - otherwise go to PREP.
//  PREP: base_r = base mod modulo via reducer A; acc = 1.
//  LOOP (0 cycles, decision only): exp_r==0 -> DONE; else launch STEP.
//  STEP:
//   - reducer A computes (base_r*base_r) mod m; reducer B computes (acc*base_r) mod m, in parallel.
//   - Commit on reducer done: base_r<=A; acc<=B only if exp_r[0]; exp_r<=exp_r>>1.
//  DONE (1 cycle): done=1, result=acc (or forced value from CHECK); busy drops in the same cycle.
//  exponent==0 with modulo>1 gives result=1.
//  Widths:
//   - products are 2*WIDTH bits, no truncation (fixes the legacy truncated product);
//   - remainders are WIDTH bits, always < modulo.
//  Reduce phase: exactly 2*WIDTH+2 cycles (1 load, 2*WIDTH shift-subtract, 1 commit).
//  Latency: done rises exactly 2 + (2*WIDTH+2)*(1+n) cycles after the start cycle,
//   where n = bit length of exponent (n=0 for exponent 0).
//   Error/modulo==1 paths: done 2 cycles after start.
//  A new start is accepted in the cycle after done (busy already 0 during done).
// STRUCTURE
//  Shared include mod_exp_defs.vh:
//   - FSM state encodings (IDLE, CHECK, PREP, LOOP, STEP, DONE);
//   - latency helper constants: REDUCE_CYCLES = 2*WIDTH+2.
//  Sub-module mod_reducer #(WIDTH):
//   - ports clk, reset, start, numer[2W], denom[W], done, remain[W];
//   - restoring division, one quotient bit per cycle; quotient not kept.
//   - Two instances (A, B) in mod_exp_engine.
// TESTING  (WIDTH=16 unless noted; compare every result with a bignum model)
//  4^13 mod 497 -> result=445, error=0, done exactly 2+34*5=172 cycles after start.
//  1000^3 mod 17 (base>=modulo) -> 7; 7^0 mod 13 -> 1 after 36 cycles.
//  modulo=0 -> error=1, result=0, done 2 cycles after start; modulo=1, any base/exp -> result=0, error=0.
//  65535^65535 mod 65521 (full width) -> matches model; WIDTH=32 random 1k vectors -> all match.
//  Back-to-back: start asserted during done cycle is accepted; extra start pulses while busy are ignored.
//  reset asserted mid-STEP -> next cycle busy=0, done=0, result=0; following op correct.

Source files
------------

// File: rtl/mod_exp_engine_pkg.sv
// Shared types and latency helpers for the modular exponentiation engine.
package mod_exp_engine_pkg;

    // Engine sequencing states; LOOP is a decision folded into the reducer commit cycle.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_PREP,
        ST_LOOP,
        ST_STEP,
        ST_DONE
    } exp_state_t;

    // Reducer states: idle/load, shift-subtract, commit.
    typedef enum logic [1:0] {
        RD_IDLE,
        RD_SHIFT,
        RD_DONE
    } red_state_t;

    // Cycles per reduce phase: 1 load, 2*width shift-subtract, 1 commit.
    function automatic int unsigned reduce_cycles(input int unsigned width);
        return 2 * width + 2;
    endfunction

endpackage

// File: rtl/mod_reducer.sv
// Restoring shift-subtract reducer: remain = numer mod denom, one numerator bit per cycle.
module mod_reducer
    import mod_exp_engine_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   numer,
    input  logic [WIDTH-1:0]     denom,
    output logic                 done,
    output logic [WIDTH-1:0]     remain
);

    localparam int unsigned NW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(NW + 1);

    red_state_t        state;
    logic [NW-1:0]     num_r;
    logic [WIDTH-1:0]  den_r;
    logic [CW-1:0]     cnt;
    logic [WIDTH:0]    trial_c;
    logic              take_c;

    // Partial remainder with the next numerator bit shifted in, and the subtract decision.
    assign trial_c = {remain, num_r[NW-1]};
    assign take_c  = (trial_c >= {1'b0, den_r});

    // Load, 2*WIDTH shift-subtract steps, then a one-cycle done pulse with remain valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RD_IDLE;
            done   <= 1'b0;
            remain <= '0;
            num_r  <= '0;
            den_r  <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                RD_IDLE: begin
                    if (start) begin
                        num_r  <= numer;
                        den_r  <= denom;
                        remain <= '0;
                        cnt    <= '0;
                        state  <= RD_SHIFT;
                    end
                end
                RD_SHIFT: begin
                    remain <= take_c ? WIDTH'(trial_c - {1'b0, den_r}) : WIDTH'(trial_c);
                    num_r  <= num_r << 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(NW - 1)) begin
                        state <= RD_DONE;
                        done  <= 1'b1;
                    end
                end
                RD_DONE: state <= RD_IDLE;
                default: state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mod_exp_engine.sv
// Modular exponentiation core, right-to-left square-and-multiply with two parallel reducers.
module mod_exp_engine
    import mod_exp_engine_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  base,
    input  logic [WIDTH-1:0]  modulo,
    input  logic [WIDTH-1:0]  exponent,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [WIDTH-1:0]  result
);

    localparam int unsigned NW = 2 * WIDTH;

    exp_state_t        state;
    logic [WIDTH-1:0]  base_r;
    logic [WIDTH-1:0]  mod_r;
    logic [WIDTH-1:0]  exp_r;
    logic [WIDTH-1:0]  acc;
    logic              red_start;
    logic [NW-1:0]     numer_a_c;
    logic [NW-1:0]     numer_b_c;
    logic [WIDTH-1:0]  exp_next_c;
    logic              red_done_a;
    logic              red_done_b;
    logic [WIDTH-1:0]  rem_a;
    logic [WIDTH-1:0]  rem_b;

    // Reducer A: base reduction in PREP, full-width square in STEP; reducer B: acc*base.
    assign numer_a_c  = (state == ST_PREP) ? NW'(base_r) : NW'(base_r) * NW'(base_r);
    assign numer_b_c  = NW'(acc) * NW'(base_r);
    assign exp_next_c = exp_r >> 1;

    mod_reducer #(.WIDTH(WIDTH)) u_red_a (
        .clk    (clk),
        .reset  (reset),
        .start  (red_start),
        .numer  (numer_a_c),
        .denom  (mod_r),
        .done   (red_done_a),
        .remain (rem_a)
    );

    mod_reducer #(.WIDTH(WIDTH)) u_red_b (
        .clk    (clk),
        .reset  (reset),
        .start  (red_start),
        .numer  (numer_b_c),
        .denom  (mod_r),
        .done   (red_done_b),
        .remain (rem_b)
    );

    // Sequencer: capture, degenerate-modulus check, base reduction, square/multiply steps.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            result    <= '0;
            base_r    <= '0;
            mod_r     <= '0;
            exp_r     <= '0;
            acc       <= '0;
            red_start <= 1'b0;
        end else begin
            red_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        base_r <= base;
                        mod_r  <= modulo;
                        exp_r  <= exponent;
                        acc    <= WIDTH'(1);
                        busy   <= 1'b1;
                        state  <= ST_CHECK;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (mod_r <= WIDTH'(1)) begin
                        result <= '0;
                        error  <= (mod_r == '0);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ST_DONE;
                    end else begin
                        red_start <= 1'b1;
                        state     <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    if (red_done_a) begin
                        base_r <= rem_a;
                        if (exp_r == '0) begin
                            result <= acc;
                            error  <= 1'b0;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= ST_DONE;
                        end else begin
                            red_start <= 1'b1;
                            state     <= ST_STEP;
                        end
                    end
                end
                ST_STEP: begin
                    if (red_done_a && red_done_b) begin
                        base_r <= rem_a;
                        exp_r  <= exp_next_c;
                        if (exp_r[0]) begin
                            acc <= rem_b;
                        end
                        if (exp_next_c == '0) begin
                            result <= exp_r[0] ? rem_b : acc;
                            error  <= 1'b0;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= ST_DONE;
                        end else begin
                            red_start <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
